// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D-cache memory arbiter.
// Imported by the arbiter top and its word counter.
package mem_arb_pkg;
    localparam int LINE_WORDS = 8;
    localparam int OFFSET_BITS = 3;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam logic [ADDR_W-1:0] LINE_MASK = 16'hFFF0;

    typedef enum logic [1:0] {
        IDLE,
        FILL_I,
        FILL_D,
        WRITE
    } arb_state_t;
endpackage

// File: rtl/mem_arbiter_word_counter.sv
// Word offset counter for line fills: enable, clear and terminal count.
// Wraps to 0 after the last word of a line.
module word_counter
    import mem_arb_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   clr,
    output logic [OFFSET_BITS-1:0] cnt,
    output logic                   tc
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == OFFSET_BITS'(LINE_WORDS - 1));
endmodule

// File: rtl/mem_arbiter.sv
// Grants main memory to the I- or D-cache and sequences line fills
// and single-word write-throughs; D-side requests win.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_service,
    output logic              i_data_valid,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_write,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_service,
    output logic              d_data_valid,
    output logic              d_write_done,
    output logic [DATA_W-1:0] fill_data,
    output logic [2:0]        fill_word,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_data_valid
);
    arb_state_t state;
    logic [ADDR_W-1:0] line_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic issue_done;

    logic [OFFSET_BITS-1:0] issue_cnt;
    logic [OFFSET_BITS-1:0] ret_cnt;
    logic issue_tc;
    logic ret_tc;
    logic in_fill;
    logic in_idle;
    logic in_write;
    logic issue_en;
    logic ret_en;

    assign in_fill = (state == FILL_I) || (state == FILL_D);
    assign in_idle = (state == IDLE);
    assign in_write = (state == WRITE);
    assign issue_en = in_fill && !issue_done;
    assign ret_en = in_fill && mem_data_valid;

    word_counter u_issue_cnt (
        .clk (clk),
        .rst (rst),
        .en  (issue_en),
        .clr (in_idle),
        .cnt (issue_cnt),
        .tc  (issue_tc)
    );

    word_counter u_ret_cnt (
        .clk (clk),
        .rst (rst),
        .en  (ret_en),
        .clr (in_idle),
        .cnt (ret_cnt),
        .tc  (ret_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            line_addr <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            issue_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    issue_done <= 1'b0;
                    if (d_write) begin
                        state <= WRITE;
                        wr_addr <= d_addr;
                        wr_data <= d_wdata;
                    end else if (d_miss) begin
                        state <= FILL_D;
                        line_addr <= d_addr & LINE_MASK;
                    end else if (i_miss) begin
                        state <= FILL_I;
                        line_addr <= i_addr & LINE_MASK;
                    end
                end
                FILL_I, FILL_D: begin
                    if (issue_en && issue_tc) begin
                        issue_done <= 1'b1;
                    end
                    // Leave on the last returned word, not the last issue.
                    if (ret_en && ret_tc) begin
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mem_enable = in_write || issue_en;
    assign mem_wr = in_write;
    assign mem_wdata = in_write ? wr_data : '0;

    always_comb begin
        mem_addr = '0;
        if (in_write) begin
            mem_addr = wr_addr;
        end else if (issue_en) begin
            mem_addr = line_addr
                     | {{(ADDR_W-OFFSET_BITS-1){1'b0}}, issue_cnt, 1'b0};
        end
    end

    assign i_service = (state == FILL_I);
    assign d_service = (state == FILL_D) || in_write;
    assign d_write_done = in_write;

    assign i_data_valid = (state == FILL_I) && mem_data_valid;
    assign d_data_valid = (state == FILL_D) && mem_data_valid;
    assign fill_data = ret_en ? mem_rdata : '0;
    assign fill_word = ret_en ? ret_cnt : '0;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single multi-cycle main memory between the I-cache and D-cache controllers. It grants one requester at a time, sequences an 8-word line fill or a single-word write-through, and routes returned read data to the granted cache. It sits between the fetch-stage and memory-stage cache controllers and the main memory.

## Interface
- LINE_WORDS, 8, 16-bit words per cache line (16-byte line)
- ADDR_W, 16, address width (byte address)
- DATA_W, 16, data width

- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- i_miss  in  1  I-cache miss detected; held until fill completes
- i_addr  in  ADDR_W  I-cache miss address; bits [3:0] ignored
- i_service  out  1  high while the I-cache fill is in progress
- i_data_valid  out  1  fill_data is a valid word for the I-cache this cycle
- d_miss  in  1  D-cache miss detected
- d_addr  in  ADDR_W  D-cache miss or write address
- d_write  in  1  D-cache write-through request
- d_wdata  in  DATA_W  write-through data
- d_service  out  1  high while a D-cache fill or write is in progress
- d_data_valid  out  1  fill_data is a valid word for the D-cache this cycle
- d_write_done  out  1  one-cycle pulse: write accepted by memory
- fill_data  out  DATA_W  returned word, shared by both caches
- fill_word  out  3  word offset of fill_data within the line
- mem_enable  out  1  memory access strobe
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_data_valid  in  1  mem_rdata valid this cycle

## Operation
- States: IDLE, FILL_I, FILL_D, WRITE.
- Requests are sampled only in IDLE. Priority: d_write > d_miss > i_miss. The memory-stage instruction is older, so D-side requests win.
- IDLE -> WRITE on d_write. WRITE lasts one cycle: mem_enable=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata, d_service=1, d_write_done=1. The arbiter then returns to IDLE.
- IDLE -> FILL_x on a miss. The line address {addr[15:4], 4'b0} is latched on entry.
- FILL: the issue counter runs 0..7. Each cycle the arbiter issues a read with mem_enable=1, mem_wr=0 and mem_addr={line[15:4], issue_cnt, 1'b0} until all 8 reads are issued.
- FILL: the return counter counts mem_data_valid. For each valid, fill_data=mem_rdata, fill_word=return_cnt, and the granted cache's *_data_valid=1. On the 8th valid the arbiter transitions to IDLE.
- *_service stays high from the first FILL cycle through the cycle of the 8th valid, inclusive.
- Return-data arithmetic: both counters are 3-bit and wrap to 0. The transition condition is return_cnt==7 && mem_data_valid.
- Boundaries:
  - Requester deasserting its miss mid-fill is ignored; the fill completes.
  - mem_data_valid in IDLE or WRITE is ignored; no *_data_valid is produced.
  - Misaligned miss address: the low 4 bits are dropped and the fill starts at word 0.
  - A pending i_miss while a D-side transaction runs waits. It is granted in the next IDLE cycle if no D request is present.
  - Reset mid-fill: state IDLE and counters cleared immediately. Stale returns are ignored.
- Reset values: state IDLE, counters 0, all outputs 0, latched line address 0.

## Timing
- Grant latency: a request seen in IDLE at cycle 0 puts the arbiter in FILL/WRITE at cycle 1.
- Fill with memory latency L:
  - Reads are issued at cycles 1..8.
  - Data returns at 1+L..8+L.
  - The arbiter is back in IDLE at 9+L; the earliest next grant is at 10+L.
- Write: d_write_done at cycle 1, IDLE at cycle 2.
- Every output except fill_data is registered state-derived. fill_data/fill_word/*_data_valid are combinational from mem_rdata/mem_data_valid and the current state.
- mem_enable is deasserted in IDLE, and in FILL once issue_cnt has completed 8 issues.

## Structure
- Package mem_arb_pkg contains:
  - the state enum (IDLE, FILL_I, FILL_D, WRITE)
  - LINE_WORDS
  - OFFSET_BITS=3
  - the line-address mask constant
- Sub-module word_counter: 3-bit counter with enable, clear, async reset and a terminal-count output. It is instantiated twice, for issue and return.

## Test plan
- d_miss, d_addr=0x1236, 4-cycle memory:
  - mem_addr sequence 0x1230, 0x1232, ..., 0x123E at cycles 1..8
  - d_data_valid at cycles 5..12 with fill_word 0..7
  - d_service falls at cycle 13
- i_miss and d_miss raised at the same cycle: D fill runs first, with i_service=0 throughout. The I fill starts the cycle after IDLE is re-entered.
- d_write addr=0x0040 data=0xBEEF concurrent with d_miss: a single write cycle (mem_wr=1, d_write_done=1) comes first, then the D fill.
- rst asserted at the 4th return of an I fill: all outputs 0 immediately. Subsequent mem_data_valid pulses produce no i_data_valid.
- i_miss dropped after 2 returns: all 8 words are still delivered and i_service is held until the 8th.
